// File: rtl/module_key_capture.sv
// Keypad key capture stage.
// Turns debounced key-held levels into single press events and assembles digit
// presses into a BCD operand. Enter commits the operand, backspace drops the
// newest digit, clear discards the entry.
`timescale 1ns/1ps

module module_key_capture #(
  parameter int MAX_DIGITS     = 3,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         key_code,
  input  logic                               key_valid,
  output logic                               key_pulse,
  output logic [3:0]                         key_last,
  output logic [4*MAX_DIGITS-1:0]            operand_live,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic [4*MAX_DIGITS-1:0]            operand_out,
  output logic                               operand_valid,
  output logic                               err_overflow
);

  localparam int W  = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  localparam logic [RW-1:0] REL_MAX  = RW'(RELEASE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DIGITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  // Entry state: IDLE = no digits, ENTRY = partial operand, FULL = no room left.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic          r_prev_valid;
  logic [RW-1:0] r_rel_cnt;
  logic [1:0]    r_state;
  logic          r_key_pulse;
  logic [3:0]    r_key_last;
  logic [W-1:0]  r_live;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_out;
  logic          r_operand_valid;
  logic          r_err_overflow;

  logic          w_accept;
  logic          w_is_digit;

  // A press counts only on a fresh rising edge after a full quiet period;
  // an edge that arrives sooner is contact bounce and is dropped.
  assign w_accept   = key_valid & ~r_prev_valid & (r_rel_cnt == REL_MAX);
  assign w_is_digit = (key_code <= 4'd9);

  // Track the previous key_valid sample and the saturating release counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_valid <= 1'b0;
      r_rel_cnt    <= REL_MAX;
    end else begin
      r_prev_valid <= key_valid;
      if (key_valid)
        r_rel_cnt <= '0;
      else if (r_rel_cnt != REL_MAX)
        r_rel_cnt <= r_rel_cnt + RW'(1);
    end
  end

  // Decode accepted presses and update the operand entry FSM and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_key_pulse     <= 1'b0;
      r_key_last      <= '0;
      r_live          <= '0;
      r_count         <= '0;
      r_out           <= '0;
      r_operand_valid <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      // Strobes fall back to zero unless this edge raises them again.
      r_key_pulse     <= 1'b0;
      r_operand_valid <= 1'b0;
      r_err_overflow  <= 1'b0;

      if (w_accept) begin
        r_key_pulse <= 1'b1;
        r_key_last  <= key_code;

        if (w_is_digit) begin
          if (r_state == S_FULL) begin
            r_err_overflow <= 1'b1;
          end else begin
            r_live  <= {r_live[W-5:0], key_code};
            r_count <= r_count + CW'(1);
            r_state <= (r_count == CNT_LAST) ? S_FULL : S_ENTRY;
          end
        end else begin
          case (key_code)
            KEY_ENTER: begin
              // An empty operand is never committed.
              if (r_state != S_IDLE) begin
                r_out           <= r_live;
                r_operand_valid <= 1'b1;
                r_live          <= '0;
                r_count         <= '0;
                r_state         <= S_IDLE;
              end
            end
            KEY_BKSP: begin
              if (r_state != S_IDLE) begin
                r_live  <= r_live >> 4;
                r_count <= r_count - CW'(1);
                r_state <= (r_count == CNT_ONE) ? S_IDLE : S_ENTRY;
              end
            end
            KEY_CLEAR: begin
              r_live  <= '0;
              r_count <= '0;
              r_state <= S_IDLE;
            end
            default: begin
              // 0xD-0xF only report the press; the operand is untouched.
            end
          endcase
        end
      end
    end
  end

  assign key_pulse     = r_key_pulse;
  assign key_last      = r_key_last;
  assign operand_live  = r_live;
  assign digit_count   = r_count;
  assign operand_out   = r_out;
  assign operand_valid = r_operand_valid;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_module_key_capture.sv
// Bench for module_key_capture: directed key sequences, a behavioural
// press/operand model compared every cycle, and hand-computed spot checks.
`timescale 1ns/1ps

module tb_module_key_capture;

  localparam int MAXD = 3;
  localparam int REL  = 4;
  localparam int W    = 4 * MAXD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   key_code = 4'h0;
  logic         key_valid = 1'b0;

  logic         key_pulse;
  logic [3:0]   key_last;
  logic [W-1:0] operand_live;
  logic [1:0]   digit_count;
  logic [W-1:0] operand_out;
  logic         operand_valid;
  logic         err_overflow;

  module_key_capture #(.MAX_DIGITS(MAXD), .RELEASE_CYCLES(REL)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_pulse     (key_pulse),
    .key_last      (key_last),
    .operand_live  (operand_live),
    .digit_count   (digit_count),
    .operand_out   (operand_out),
    .operand_valid (operand_valid),
    .err_overflow  (err_overflow)
  );

  // About 27 MHz.
  always #18.5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_quiet = REL;   // consecutive key_valid=0 samples seen
  bit         m_prev  = 1'b0;
  int         m_digits[$];     // entered digits, oldest first
  logic [3:0] m_last  = 4'h0;
  int         m_out   = 0;
  bit         m_pulse = 1'b0;
  bit         m_ov    = 1'b0;
  bit         m_err   = 1'b0;

  function automatic int live_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_quiet = REL;
    m_prev  = 1'b0;
    m_digits.delete();
    m_last  = 4'h0;
    m_out   = 0;
    m_pulse = 1'b0;
    m_ov    = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    m_pulse = 1'b0;
    m_ov    = 1'b0;
    m_err   = 1'b0;
    if (key_valid && !m_prev && m_quiet >= REL) begin
      m_pulse = 1'b1;
      m_last  = key_code;
      if (key_code <= 4'd9) begin
        if (m_digits.size() == MAXD) m_err = 1'b1;
        else m_digits.push_back(int'(key_code));
      end else if (key_code == 4'hA) begin
        if (m_digits.size() > 0) begin
          m_out = live_value();
          m_ov  = 1'b1;
          m_digits.delete();
        end
      end else if (key_code == 4'hB) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
      end else if (key_code == 4'hC) begin
        m_digits.delete();
      end
    end
    if (key_valid) m_quiet = 0;
    else if (m_quiet < REL) m_quiet++;
    m_prev = key_valid;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else model_step();
  end

  // ---------------- compare process + event counters ----------------
  int n_pulse = 0;
  int n_ov    = 0;
  int n_err   = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("key_pulse",     32'(key_pulse),     32'(m_pulse));
      check("key_last",      32'(key_last),      32'(m_last));
      check("operand_live",  32'(operand_live),  32'(live_value()));
      check("digit_count",   32'(digit_count),   32'(m_digits.size()));
      check("operand_out",   32'(operand_out),   32'(m_out));
      check("operand_valid", 32'(operand_valid), 32'(m_ov));
      check("err_overflow",  32'(err_overflow),  32'(m_err));
      if (key_pulse)     n_pulse++;
      if (operand_valid) n_ov++;
      if (err_overflow)  n_err++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_code  = c;
    key_valid = 1'b1;
    repeat (10) @(negedge clk);
    key_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " key_pulse"},     32'(key_pulse),     32'h0);
    check({tag, " key_last"},      32'(key_last),      32'h0);
    check({tag, " operand_live"},  32'(operand_live),  32'h0);
    check({tag, " digit_count"},   32'(digit_count),   32'h0);
    check({tag, " operand_out"},   32'(operand_out),   32'h0);
    check({tag, " operand_valid"}, 32'(operand_valid), 32'h0);
    check({tag, " err_overflow"},  32'(err_overflow),  32'h0);
  endtask

  int p0, v0, e0;

  initial begin
    // 1: reset, then idle with no keys
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("t1 in reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("t1 idle");
    check("t1 pulses", 32'(n_pulse), 32'd0);

    // 2: enter 1,2,3 and commit
    p0 = n_pulse; v0 = n_ov;
    press(4'h1); check("t2 live 1",   32'(operand_live), 32'h001);
    press(4'h2); check("t2 live 12",  32'(operand_live), 32'h012);
    press(4'h3); check("t2 live 123", 32'(operand_live), 32'h123);
    check("t2 count full", 32'(digit_count), 32'd3);
    press(4'hA);
    check("t2 operand_out", 32'(operand_out), 32'h123);
    check("t2 valid strobes", 32'(n_ov - v0), 32'd1);
    check("t2 key pulses", 32'(n_pulse - p0), 32'd4);
    check("t2 count", 32'(digit_count), 32'd0);
    check("t2 live cleared", 32'(operand_live), 32'h000);

    // 3: bounce on the press of 5
    p0 = n_pulse;
    @(negedge clk);
    key_code = 4'h5; key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    key_valid = 1'b1;
    repeat (8) @(negedge clk);
    key_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t3 one pulse", 32'(n_pulse - p0), 32'd1);
    check("t3 live", 32'(operand_live), 32'h005);

    // 4: overflow, backspace, clear
    press(4'hC);
    e0 = n_err; v0 = n_ov;
    press(4'h1); press(4'h2); press(4'h3);
    press(4'h4);
    check("t4 overflow strobe", 32'(n_err - e0), 32'd1);
    check("t4 live kept", 32'(operand_live), 32'h123);
    check("t4 count kept", 32'(digit_count), 32'd3);
    press(4'hB);
    check("t4 bksp live", 32'(operand_live), 32'h012);
    check("t4 bksp count", 32'(digit_count), 32'd2);
    press(4'hC);
    check("t4 clear live", 32'(operand_live), 32'h000);
    check("t4 clear count", 32'(digit_count), 32'd0);
    check("t4 out kept", 32'(operand_out), 32'h123);
    check("t4 no commit", 32'(n_ov - v0), 32'd0);

    // 5: enter from IDLE, no-op key D
    p0 = n_pulse; v0 = n_ov;
    press(4'hA);
    check("t5 enter pulse", 32'(n_pulse - p0), 32'd1);
    check("t5 no valid", 32'(n_ov - v0), 32'd0);
    check("t5 key_last A", 32'(key_last), 32'hA);
    press(4'hD);
    check("t5 key_last D", 32'(key_last), 32'hD);
    check("t5 live", 32'(operand_live), 32'h000);

    // 6: asynchronous reset while 7 is held
    press(4'h5); press(4'h6);
    check("t6 live 56", 32'(operand_live), 32'h056);
    @(negedge clk);
    key_code = 4'h7; key_valid = 1'b1;
    repeat (3) @(negedge clk);
    #5 rst = 1'b0;
    #1 check_all_zero("t6 async reset");
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    press(4'h7);
    check("t6 live 7", 32'(operand_live), 32'h007);
    check("t6 count", 32'(digit_count), 32'd1);
    check("t6 out reset", 32'(operand_out), 32'h000);
    check("t6 key_last", 32'(key_last), 32'h7);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
